// File: rtl/aer_uart_tx.sv
// rtl/aer_uart_tx.sv - AER spike events to 2-byte UART frames via FIFO (AER_UART_TX_DROP_EN: drop events when full)
module aer_uart_tx #(
  parameter int          PRESCALE   = 30,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  HDR_NIBBLE = 4'h2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  aerout_addr,
  input  logic        aerout_req,
  output logic        aerout_ack,
  output logic        txd,
  output logic        busy,
  output logic        fifo_full,
  output logic [15:0] drop_cnt
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BIT_CYC = 8 * PRESCALE;
  localparam int CW      = $clog2(BIT_CYC);

  typedef enum logic {HS_IDLE, HS_ACK} hs_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_ADDR} tx_state_t;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        push, pop;

  hs_state_t   hs_state_q, hs_state_d;
  logic        ack_q, ack_d;

  tx_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        txd_q, txd_d;
  logic [7:0]  cur_byte;
  logic [9:0]  frame_bits;
  logic        bit_end;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem[rd_ptr_q[AW-1:0]];
  assign aerout_ack = ack_q;
  assign txd        = txd_q;
  assign busy       = (tx_state_q != TX_IDLE) || !fifo_empty;

`ifdef AER_UART_TX_DROP_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

  // Event storage; data needs no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= aerout_addr;
  end

  // 4-phase handshake: accept once per req high phase, ack follows the accept
  always_comb begin
    hs_state_d = hs_state_q;
    ack_d      = ack_q;
    push       = 1'b0;
`ifdef AER_UART_TX_DROP_EN
    drop       = 1'b0;
`endif
    case (hs_state_q)
      HS_IDLE: begin
        if (aerout_req) begin
          if (!fifo_full) begin
            push       = 1'b1;
            hs_state_d = HS_ACK;
            ack_d      = 1'b1;
          end
`ifdef AER_UART_TX_DROP_EN
          else begin
            drop       = 1'b1;
            hs_state_d = HS_ACK;
            ack_d      = 1'b1;
          end
`endif
        end
      end
      default: begin
        if (!aerout_req) begin
          hs_state_d = HS_IDLE;
          ack_d      = 1'b0;
        end
      end
    endcase
  end

  // Serializer: header then address byte, chaining frames with no idle gap
  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    pop        = 1'b0;
    bit_end    = (cnt_q == CW'(BIT_CYC - 1));
    cur_byte   = (tx_state_q == TX_HDR) ? {HDR_NIBBLE, 4'b0000} : byte_q;
    frame_bits = {1'b1, cur_byte, 1'b0};
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          byte_d     = fifo_head;
          tx_state_d = TX_HDR;
          cnt_d      = '0;
          bit_d      = 4'd0;
        end
      end
      TX_HDR, TX_ADDR: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (tx_state_q == TX_HDR) begin
              tx_state_d = TX_ADDR;
            end else if (!fifo_empty) begin
              pop        = 1'b1;
              byte_d     = fifo_head;
              tx_state_d = TX_HDR;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // txd is registered one cycle behind the serializer state
    txd_d = (tx_state_q == TX_IDLE) ? 1'b1 : frame_bits[bit_q];
  end

  // Pointer next-state: simultaneous push and pop both take effect
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
  end

`ifdef AER_UART_TX_DROP_EN
  // Saturating count of events discarded while the FIFO was full
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 16'h0000;
    else        drop_cnt_q <= drop_cnt_d;
  end
`endif

  // State registers; reset abandons any frame in flight and empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hs_state_q <= HS_IDLE;
      ack_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      byte_q     <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hs_state_q <= hs_state_d;
      ack_q      <= ack_d;
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      txd_q      <= txd_d;
    end
  end
endmodule

// File: tb/tb_aer_uart_tx.sv
// tb/tb_aer_uart_tx.sv - scoreboard bench for aer_uart_tx with PRESCALE=2
module tb_aer_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  aerout_addr = 8'h00;
  logic        aerout_req = 1'b0;
  logic        aerout_ack;
  logic        txd;
  logic        busy;
  logic        fifo_full;
  logic [15:0] drop_cnt;

  aer_uart_tx #(.PRESCALE(2), .FIFO_DEPTH(16), .HDR_NIBBLE(4'h2)) dut (
    .clk(clk), .rst_n(rst_n), .aerout_addr(aerout_addr), .aerout_req(aerout_req),
    .aerout_ack(aerout_ack), .txd(txd), .busy(busy), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // UART monitor: decodes txd at mid-bit and compares against the scoreboard
  bit         rx_act = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_b = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (txd == 1'b0) begin
        rx_act = 1'b1;
        rx_n = 0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_n++;
      if (rx_n == 8) chk("start_bit", int'(txd), 0);
      if (rx_n >= 24 && rx_n <= 136 && ((rx_n - 24) % 16) == 0) rx_b[(rx_n - 24) / 16] = txd;
      if (rx_n == 152) begin
        chk("stop_bit", int'(txd), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_b);
        end else begin
          chk("byte", int'(rx_b), int'(exp_q.pop_front()));
        end
        rx_act = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] a, output int n, output int c0);
    int m;
    aerout_addr = a;
    aerout_req  = 1'b1;
    c0 = cyc;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!aerout_ack && n < 2000);
    if (!aerout_ack) chk("ack_timeout", n, -1);
    aerout_req = 1'b0;
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (aerout_ack && m < 10);
    if (aerout_ack) chk("ack_release", int'(aerout_ack), 0);
  endtask

  task automatic wait_idle(output int c);
    int k;
    k = 0;
    while (busy && k < 10000) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) chk("idle_timeout", k, -1);
    c = cyc;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] a);
    exp_q.push_back(8'h20);
    exp_q.push_back(a);
  endtask

  initial begin
    int n, c0, cf, k;
    // asynchronous reset with no clock edge yet
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txd", int'(txd), 1);
    chk("rst_ack", int'(aerout_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single event: latency, frame timing
    start_q.delete();
    push_frame(8'h5A);
    send(8'h5A, n, c0);
    chk("single_ack_wait", n, 1);
    wait_idle(cf);
    chk("single_busy_fall", cf - c0, 322);
    chk("single_nbytes", start_q.size(), 2);
    if (start_q.size() >= 2) begin
      chk("single_latency", start_q[0] - c0, 3);
      chk("single_byte_gap", start_q[1] - start_q[0], 160);
    end
    chk("single_txd_idle", int'(txd), 1);

    // back-to-back frames, no gap
    start_q.delete();
    push_frame(8'hFF);
    push_frame(8'h00);
    send(8'hFF, n, c0);
    send(8'h00, n, k);
    wait_idle(cf);
    chk("b2b_busy_fall", cf - c0, 642);
    chk("b2b_nbytes", start_q.size(), 4);
    if (start_q.size() >= 4) begin
      chk("b2b_gap1", start_q[1] - start_q[0], 160);
      chk("b2b_gap2", start_q[2] - start_q[0], 320);
      chk("b2b_gap3", start_q[3] - start_q[0], 480);
    end

    // 18 fast events into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
`ifdef AER_UART_TX_DROP_EN
      if (i < 17) push_frame(8'(8'h30 + i));
`else
      push_frame(8'(8'h30 + i));
`endif
      if (i == 17) chk("burst_full_before_18", int'(fifo_full), 1);
      send(8'(8'h30 + i), n, c0);
      if (i < 17) chk("burst_ack_wait", n, 1);
`ifdef AER_UART_TX_DROP_EN
      else chk("burst_ack18_immediate", n, 1);
`else
      else chk("burst_ack18_withheld", int'(n > 200 && n < 340), 1);
`endif
    end
`ifdef AER_UART_TX_DROP_EN
    chk("burst_drop_cnt", int'(drop_cnt), 1);
`else
    chk("burst_drop_cnt", int'(drop_cnt), 0);
`endif
    wait_idle(cf);
    chk("burst_all_sent", exp_q.size(), 0);

    // reset during the address byte
    start_q.delete();
    push_frame(8'hA5);
    send(8'hA5, n, c0);
    k = 0;
    while (start_q.size() < 2 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mid_reached_addr", int'(start_q.size() >= 2), 1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", int'(txd), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_full", int'(fifo_full), 0);
    chk("mid_rst_ack", int'(aerout_ack), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("mid_no_resume_txd", int'(txd), 1);
    chk("mid_no_resume_busy", int'(busy), 0);
    start_q.delete();
    push_frame(8'h3C);
    send(8'h3C, n, c0);
    wait_idle(cf);
    chk("mid_clean_nbytes", start_q.size(), 2);
    chk("mid_clean_busy_fall", cf - c0, 322);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aer_uart_tx.md
AER_UART_TX -- requirements
Module: aer_uart_tx

Interface
REQ-001 Parameter PRESCALE, default 30, UART bit period = 8*PRESCALE clk cycles (PRESCALE >= 1).
REQ-002 Parameter FIFO_DEPTH, default 16, event FIFO entries (power of 2, >= 2).
REQ-003 Parameter HDR_NIBBLE, default 4'h2, upper nibble of the frame header byte.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 aerout_addr  input  8  output-spike neuron address, valid while aerout_req high.
REQ-007 aerout_req  input  1  4-phase AER request from the core (same clock domain).
REQ-008 aerout_ack  output  1  4-phase AER acknowledge.
REQ-009 txd  output  1  UART serial output, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high while a frame is on txd or the FIFO is non-empty.
REQ-011 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 drop_cnt  output  16  dropped-event count (see Configuration).

Function
REQ-013 Each event SHALL be sent as a 2-byte frame: header {HDR_NIBBLE, 4'b0000}, then aerout_addr.
REQ-014 Handshake FSM states IDLE, ACK; IDLE->ACK when aerout_req sampled high and event accepted; ACK->IDLE when aerout_req sampled low.
REQ-015 On acceptance, aerout_addr SHALL be written to the FIFO and aerout_ack driven high on the next cycle; aerout_ack SHALL fall the cycle after aerout_req is sampled low.
REQ-016 An event SHALL be written exactly once per req rising phase, regardless of how long req stays high.
REQ-017 With FIFO full and macro off, aerout_ack SHALL stay low until a slot frees; the event is then accepted with no loss.
REQ-018 TX FSM states IDLE, HDR, ADDR; IDLE->HDR pops the FIFO head into the TX register when FIFO non-empty; HDR->ADDR after header stop bit; ADDR->HDR (FIFO non-empty) or IDLE after address stop bit.
REQ-019 Each byte: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly 8*PRESCALE cycles; frame = 160*PRESCALE cycles.
REQ-020 Back-to-back frames SHALL have no idle gap after the stop bit.
REQ-021 Latency: with FIFO empty and TX IDLE, txd SHALL fall exactly 2 cycles after aerout_req is first sampled high.
REQ-022 Simultaneous FIFO write and pop SHALL both occur; full/empty flags SHALL reflect the net count.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.

Reset
REQ-024 rst_n low SHALL immediately force txd=1, aerout_ack=0, busy=0, fifo_full=0, drop_cnt=0, both FSMs to IDLE, FIFO empty.
REQ-025 Reset mid-frame SHALL abandon the frame; no partial frame resumes after release.
REQ-026 After release, an aerout_req already high SHALL be treated as a new request.

Configuration
REQ-027 Macro AER_UART_TX_DROP_EN defined: with FIFO full, a request SHALL be acked per REQ-015, the event discarded, drop_cnt incremented, saturating at 16'hFFFF.
REQ-028 AER_UART_TX_DROP_EN undefined: backpressure per REQ-017; drop_cnt SHALL be tied to 0.

Verification (PRESCALE=2, bit=16 cycles, FIFO_DEPTH=16)
REQ-029 Reset asserted -> txd=1, aerout_ack=0, busy=0, drop_cnt=0 without clock edge.
REQ-030 Single event addr 8'h5A -> txd start at req+2 cycles, bytes 8'h20 then 8'h5A LSB first, idle after 320 cycles.
REQ-031 Event addr 8'hFF then 8'h00 back-to-back -> frames 20 FF 20 00, no gap, total 640 cycles.
REQ-032 18 events fast, macro off -> 17 acked immediately, 18th ack withheld until first frame ends (cycle ~320), all 18 frames sent in order.
REQ-033 Same stimulus, AER_UART_TX_DROP_EN -> 18 acks immediate, drop_cnt=1, 17 frames sent.
REQ-034 rst_n pulsed during address byte -> txd high at once, FIFO empty, next event transmits a clean full frame.
